branch_predict_ctrl: RTL and testbench

- Branch prediction and resolution controller for the 5-stage pipeline.
- In IF, predicts conditional branches using a 2-bit saturating-counter BHT and a direct-mapped BTB.
- In EX, takes the branch comparator result, trains the tables, and on a mispredict drives the IF/ID and ID/EX flushes plus a PC redirect.
- Also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : Branch prediction and resolution controller for a 5-stage
//            pipeline. In IF it predicts conditional branches from a 2-bit
//            saturating-counter BHT and a direct-mapped BTB. In EX it
//            resolves the branch, trains both tables, and on a mispredict
//            flushes IF/ID and ID/EX and redirects the PC. It also keeps
//            saturating branch and mispredict statistics counters.
// Ports    :
//   clk, rstn            - clock (rising edge), async active-low reset
//   if_pc                - fetch PC used to look up the prediction
//   pred_taken/_target   - IF prediction
//   ex_valid, ex_stall   - EX holds a real instruction / EX is frozen
//   ex_br_type           - 01=beq, 10=blt, others are not conditional branches
//   ex_br                - comparator result for the EX instruction
//   ex_pc, ex_target     - EX instruction PC and computed target
//   ex_pred_taken/_target- prediction that travelled with the instruction
//   flush_ifid/_idex     - pipeline register clears
//   redirect, redirect_pc- PC mux select and corrected fetch address
//   br_count             - resolved conditional branches (saturating)
//   mispred_count        - mispredicts (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [1:0]  ex_br_type,
    input  logic        ex_br,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [1:0]  cnt_q     [DEPTH];
    logic [31:0] btb_tgt_q [DEPTH];
    logic        btb_v_q   [DEPTH];

    logic [31:0] br_cnt_q;
    logic [31:0] br_cnt_d;
    logic [31:0] mis_cnt_q;
    logic [31:0] mis_cnt_d;
    logic [1:0]  cnt_d;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_is_cond;
    logic             w_res;
    logic             w_mis;

    // PC bits outside the index field do not take part in table lookup.
    logic w_unused;
    assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_ex_idx  = ex_pc[IDX_W+1:2];
    assign w_is_cond = (ex_br_type == 2'b01) || (ex_br_type == 2'b10);

    // rstn is folded in so every output drops the moment reset asserts,
    // independent of whatever EX is presenting.
    assign w_res = rstn & ex_valid & ~ex_stall & w_is_cond & (state_q == ST_RUN);
    assign w_mis = w_res & ((ex_br != ex_pred_taken) |
                            (ex_br & ex_pred_taken & (ex_target != ex_pred_target)));

    // ------------------------------------------------------------------
    // Prediction: reads pre-update table contents, so a same-index write
    // in this cycle is only visible after the clock edge.
    // ------------------------------------------------------------------
    assign pred_taken  = rstn & cnt_q[w_if_idx][1] & btb_v_q[w_if_idx];
    assign pred_target = btb_tgt_q[w_if_idx];

    // ------------------------------------------------------------------
    // Mispredict outputs
    // ------------------------------------------------------------------
    assign flush_ifid  = w_mis;
    assign flush_idex  = w_mis;
    assign redirect    = w_mis;
    assign redirect_pc = w_mis ? (ex_br ? ex_target : ex_pc + 32'd4) : 32'd0;

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

    // ------------------------------------------------------------------
    // FSM: a mispredict is followed by one RECOVER cycle in which the
    // instruction in EX is a flush bubble or stale value and must not be
    // allowed to resolve. A stalled EX holds the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!ex_stall) begin
            case (state_q)
                ST_RUN:     if (w_mis) state_d = ST_RECOVER;
                ST_RECOVER: state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Training next-values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q[w_ex_idx];
        if (ex_br) begin
            if (cnt_q[w_ex_idx] != 2'b11) cnt_d = cnt_q[w_ex_idx] + 2'd1;
        end else begin
            if (cnt_q[w_ex_idx] != 2'b00) cnt_d = cnt_q[w_ex_idx] - 2'd1;
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (w_res && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d  = br_cnt_q + 32'd1;
        if (w_mis && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
    end

    // ------------------------------------------------------------------
    // BHT counters and BTB valid bits (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                cnt_q[k]   <= CNT_INIT;
                btb_v_q[k] <= 1'b0;
            end
        end else if (w_res) begin
            cnt_q[w_ex_idx] <= cnt_d;
            if (ex_br) btb_v_q[w_ex_idx] <= 1'b1;
        end
    end

    // BTB targets are qualified by btb_v_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_res && ex_br) begin
            btb_tgt_q[w_ex_idx] <= ex_target;
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Purpose  : Self-checking bench for branch_predict_ctrl. Table of directed
//            one-cycle vectors with hand-computed expectations, followed by
//            hand-written sequences for counter saturation and reset while
//            a flush is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rstn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_stall;
    logic [1:0]  ex_br_type;
    logic        ex_br;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush_ifid;
    logic        flush_idex;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int total = 0;
    int bad   = 0;

    branch_predict_ctrl #(.IDX_W(4), .CNT_INIT(2'b01)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_br_type     (ex_br_type),
        .ex_br          (ex_br),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ipc;
        logic        v;
        logic        st;
        logic [1:0]  ty;
        logic        br;
        logic [31:0] epc;
        logic [31:0] etg;
        logic        ept;
        logic [31:0] eptg;
        // expected (counters are the values before this cycle's edge)
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [31:0] ipc, input logic v, input logic st,
                                input logic [1:0] ty, input logic br, input logic [31:0] epc,
                                input logic [31:0] etg, input logic ept, input logic [31:0] eptg,
                                input logic pt, input logic [31:0] ptg, input logic fl,
                                input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
        vec_t r;
        r.ipc = ipc; r.v = v; r.st = st; r.ty = ty; r.br = br; r.epc = epc;
        r.etg = etg; r.ept = ept; r.eptg = eptg; r.pt = pt; r.ptg = ptg;
        r.fl = fl; r.rpc = rpc; r.bc = bc; r.mc = mc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        if_pc          = x.ipc;
        ex_valid       = x.v;
        ex_stall       = x.st;
        ex_br_type     = x.ty;
        ex_br          = x.br;
        ex_pc          = x.epc;
        ex_target      = x.etg;
        ex_pred_taken  = x.ept;
        ex_pred_target = x.eptg;
    endtask

    task automatic check_vec(input string tag, input vec_t x);
        chk({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, x.pt});
        if (x.pt) chk({tag, "_pred_target"}, pred_target, x.ptg);
        chk({tag, "_flush_ifid"}, {31'd0, flush_ifid}, {31'd0, x.fl});
        chk({tag, "_flush_idex"}, {31'd0, flush_idex}, {31'd0, x.fl});
        chk({tag, "_redirect"},   {31'd0, redirect},   {31'd0, x.fl});
        chk({tag, "_redirect_pc"}, redirect_pc, x.rpc);
        chk({tag, "_br_count"},    br_count, x.bc);
        chk({tag, "_mispred_count"}, mispred_count, x.mc);
    endtask

    vec_t tmp;

    initial begin
        //            ipc     v  st ty     br epc           etg      ept eptg     pt ptg    fl rpc    bc mc
        tbl[0]  = mk(32'h40, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 0); // idle
        tbl[1]  = mk(32'h40, 1, 0, 2'b01, 1, 32'h40,       32'h80,  0, 32'h0,   0, 32'h0,  1, 32'h80,  0, 0); // beq miss 01->10
        tbl[2]  = mk(32'h40, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   1, 1); // RECOVER
        tbl[3]  = mk(32'h40, 1, 0, 2'b01, 1, 32'h40,       32'h80,  1, 32'h80,  1, 32'h80, 0, 32'h0,   1, 1); // 10->11
        tbl[4]  = mk(32'h40, 1, 0, 2'b01, 1, 32'h40,       32'h80,  1, 32'h80,  1, 32'h80, 0, 32'h0,   2, 1); // 11 sat
        tbl[5]  = mk(32'h40, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   3, 1);
        tbl[6]  = mk(32'h40, 1, 0, 2'b10, 0, 32'h100,      32'h180, 1, 32'h180, 1, 32'h80, 1, 32'h104, 3, 1); // blt NT
        tbl[7]  = mk(32'h40, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   4, 2);
        tbl[8]  = mk(32'h44, 1, 0, 2'b01, 1, 32'h44,       32'h240, 1, 32'h200, 0, 32'h0,  1, 32'h240, 4, 2); // wrong target
        tbl[9]  = mk(32'h44, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h240,0, 32'h0,   5, 3);
        tbl[10] = mk(32'h48, 1, 0, 2'b10, 1, 32'h48,       32'h300, 0, 32'h0,   0, 32'h0,  1, 32'h300, 5, 3); // b2b #1
        tbl[11] = mk(32'h4C, 1, 0, 2'b01, 1, 32'h4C,       32'h400, 0, 32'h0,   0, 32'h0,  0, 32'h0,   6, 4); // b2b #2 ignored
        tbl[12] = mk(32'h4C, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   6, 4);
        tbl[13] = mk(32'h50, 1, 1, 2'b01, 1, 32'h50,       32'h500, 0, 32'h0,   0, 32'h0,  0, 32'h0,   6, 4); // stalled
        tbl[14] = mk(32'h50, 1, 0, 2'b01, 1, 32'h50,       32'h500, 0, 32'h0,   0, 32'h0,  1, 32'h500, 6, 4); // unstalled
        tbl[15] = mk(32'h50, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h500,0, 32'h0,   7, 5);
        tbl[16] = mk(32'h54, 1, 0, 2'b11, 1, 32'h54,       32'h600, 0, 32'h0,   0, 32'h0,  0, 32'h0,   7, 5); // type 11
        tbl[17] = mk(32'h54, 1, 0, 2'b00, 1, 32'h54,       32'h600, 0, 32'h0,   0, 32'h0,  0, 32'h0,   7, 5); // type 00
        tbl[18] = mk(32'h54, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   7, 5);
        tbl[19] = mk(32'h44, 1, 0, 2'b10, 0, 32'h44,       32'h240, 1, 32'h240, 1, 32'h240,1, 32'h48,  7, 5); // same idx
        tbl[20] = mk(32'h44, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   0, 32'h0,  0, 32'h0,   8, 6);
        tbl[21] = mk(32'h40, 1, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h10,  1, 32'h10,  1, 32'h80, 1, 32'h0,   8, 6); // pc+4 wrap
        tbl[22] = mk(32'h40, 0, 0, 2'b00, 0, 32'h0,        32'h0,   0, 32'h0,   1, 32'h80, 0, 32'h0,   9, 7);

        // Reset state
        rstn = 1'b0;
        drive(tbl[0]);
        #3;
        check_vec("reset", tbl[0]);

        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec($sformatf("v%0d", i), tbl[i]);
        end

        // Saturation of br_count: preload near the top, then resolve three
        // correctly predicted branches (idx0 counter is 10 with target 0x80).
        @(negedge clk);
        drive(tbl[0]);
        force dut.br_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        #1;
        chk("sat_preload", br_count, 32'hFFFF_FFFE);
        tmp = mk(32'h40, 1, 0, 2'b01, 1, 32'h40, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0, 0, 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(tmp);
            #1;
            chk($sformatf("sat%0d_flush", i), {31'd0, flush_ifid}, 32'd0);
            if (i > 0) chk($sformatf("sat%0d_br_count", i), br_count, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        drive(tbl[0]);
        #1;
        chk("sat_final_br_count", br_count, 32'hFFFF_FFFF);
        chk("sat_final_mispred", mispred_count, 32'd7);

        // Reset asserted while a flush is being driven.
        @(negedge clk);
        tmp = mk(32'h40, 1, 0, 2'b01, 1, 32'h58, 32'h700, 0, 32'h0, 1, 32'h80, 1, 32'h700, 32'hFFFF_FFFF, 7);
        drive(tmp);
        #1;
        chk("rst_pre_flush", {31'd0, flush_ifid}, 32'd1);
        chk("rst_pre_rpc", redirect_pc, 32'h700);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_flush_ifid", {31'd0, flush_ifid}, 32'd0);
        chk("rst_flush_idex", {31'd0, flush_idex}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mispred", mispred_count, 32'd0);

        @(negedge clk);
        drive(tbl[0]);
        rstn = 1'b1;
        #1;
        chk("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("post_rst_br_count", br_count, 32'd0);

        // FSM back in RUN after reset: a mispredict redirects immediately.
        @(negedge clk);
        drive(tbl[1]);
        #1;
        chk("post_rst_flush", {31'd0, flush_ifid}, 32'd1);
        chk("post_rst_rpc", redirect_pc, 32'h80);

        @(negedge clk);
        drive(tbl[0]);
        #1;
        chk("post_rst_br_count2", br_count, 32'd1);
        chk("post_rst_mispred2", mispred_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
